// File: rtl/tick_generator_if.sv
// Control and status bundle of the tick generator: channel enables, phase
// clear and configuration writes in; tick, square-wave and busy flags out.
interface tick_generator_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);

  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] sq_o;
  logic [NUM_CH-1:0] busy_o;

  modport master (
    output ch_en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  tick_o, sq_o, busy_o
  );

  modport slave (
    input  ch_en, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output tick_o, sq_o, busy_o
  );

endinterface

// File: rtl/tick_generator.sv
// Multi-channel programmable tick and square-wave generator. Each channel
// divides clk_100mhz by (div+1), free-running or one-shot; all outputs registered.
module tick_generator #(
  parameter int                       NUM_CH    = 2,
  parameter int                       CNT_W     = 16,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT  = {16'd6249, 16'd49999},
  parameter logic [NUM_CH-1:0]        MODE_INIT = '0
) (
  input  logic            clk_100mhz,
  input  logic            rst,
  tick_generator_if.slave bus
);

  typedef enum logic {
    CH_ARMED = 1'b0,
    CH_FIRED = 1'b1
  } ch_state_t;

  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] busy_q, busy_d;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]   <= '0;
        div_q[c]   <= DIV_INIT[c*CNT_W +: CNT_W];
        state_q[c] <= CH_ARMED;
      end
      mode_q <= MODE_INIT;
      tick_q <= '0;
      sq_q   <= '0;
      busy_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]   <= cnt_d[c];
        div_q[c]   <= div_d[c];
        state_q[c] <= state_d[c];
      end
      mode_q <= mode_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      busy_q <= busy_d;
    end
  end

  // Per-channel priority: phase clear, then a config write addressed to this
  // channel, then counting. Busy is derived from the post-edge armed state so
  // it drops on the same edge a one-shot fires.
  always_comb begin
    mode_d = mode_q;
    tick_d = '0;
    sq_d   = sq_q;
    busy_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]   = cnt_q[c];
      div_d[c]   = div_q[c];
      state_d[c] = state_q[c];
      if (bus.sync_clr) begin
        cnt_d[c]   = '0;
        sq_d[c]    = 1'b0;
        state_d[c] = CH_ARMED;
      end else if (bus.cfg_we && (bus.cfg_ch == 3'(c))) begin
        div_d[c]   = bus.cfg_div;
        mode_d[c]  = bus.cfg_mode;
        cnt_d[c]   = '0;
        state_d[c] = CH_ARMED;
      end else if (bus.ch_en[c] && (state_q[c] == CH_ARMED)) begin
        if (cnt_q[c] == div_q[c]) begin
          cnt_d[c]  = '0;
          tick_d[c] = 1'b1;
          sq_d[c]   = ~sq_q[c];
          if (mode_q[c]) begin
            state_d[c] = CH_FIRED;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      busy_d[c] = (state_d[c] == CH_ARMED) && bus.ch_en[c];
    end
  end

  assign bus.tick_o = tick_q;
  assign bus.sq_o   = sq_q;
  assign bus.busy_o = busy_q;

  // The counter is always cleared on every path that changes div, so it can
  // never run past it; a fired one-shot parks at zero.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    a_cnt_le_div : assert property (@(posedge clk_100mhz) disable iff (rst)
      cnt_q[g] <= div_q[g]);
    a_fired_idle : assert property (@(posedge clk_100mhz) disable iff (rst)
      (state_q[g] == CH_FIRED) |-> (cnt_q[g] == '0));
  end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Multi-channel programmable tick and square-wave generator. Successor to the fixed two-output clock divider.
- Each channel has a runtime-loadable divisor, an enable, and a free-run or one-shot mode.
- Outputs are single-cycle tick enables plus 50%-duty toggle outputs, all in the clk_100mhz domain.
- Feeds the stopwatch timebase (1 ms tick) and the display refresh scanner. Downstream logic uses tick_o as a clock enable, never as a clock.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
CNT_W, 16, counter and divisor width in bits
DIV_INIT, {16'd6249, 16'd49999}, packed NUM_CH*CNT_W reset divisors; channel c uses bits [c*CNT_W +: CNT_W]
MODE_INIT, 2'b00, packed NUM_CH reset modes; 0 = free-run, 1 = one-shot

Ports:
clk_100mhz  in  1  system clock
rst  in  1  synchronous active-high reset
ch_en  in  NUM_CH  per-channel count enable, level-sensitive
sync_clr  in  1  clears all counters and toggle outputs together (phase alignment)
cfg_we  in  1  configuration write strobe, one cycle
cfg_ch  in  3  channel index for cfg_we
cfg_div  in  CNT_W  new divisor for cfg_ch
cfg_mode  in  1  new mode for cfg_ch
tick_o  out  NUM_CH  one-cycle pulse per divided period
sq_o  out  NUM_CH  toggle output, period 2*(div+1) cycles
busy_o  out  NUM_CH  channel armed (free-run: equals ch_en; one-shot: armed and not yet fired)

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Per channel on reset: cnt=0, div=DIV_INIT slice, mode=MODE_INIT bit, armed=1.
  - Outputs on reset: tick_o=0, sq_o=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Priority per edge: rst > sync_clr > cfg write to the channel > counting.
- Counting: on an edge where ch_en[c] && armed[c]:
  - If cnt==div: cnt<=0, tick_o[c]<=1, sq_o[c]<=~sq_o[c].
  - Else: cnt<=cnt+1, tick_o[c]<=0.
- Counter wrap and divisor range:
  - cnt never exceeds div.
  - div=0: tick every cycle, sq toggles every cycle.
  - div=2^CNT_W-1 is legal; cnt never overflows.
- Tick period is div+1 cycles.
  - With ch_en high from the first post-reset edge, the first tick_o appears on edge div+1.
- ch_en low: cnt, sq_o and armed hold their values; tick_o=0. Re-enabling resumes from the held count.
- One-shot (mode=1): on the firing edge, tick_o=1 and armed<=0; the counter then stays at 0. The channel re-arms only on cfg write or sync_clr.
- sync_clr: all channels get cnt=0, sq_o=0, tick_o=0, armed=1. div and mode are unchanged.
- cfg write (cfg_we && cfg_ch<NUM_CH):
  - Channel cfg_ch gets div<=cfg_div, mode<=cfg_mode, cnt<=0, armed<=1, tick_o<=0.
  - sq_o for that channel is unchanged.
  - The new period counts from the next edge.
- cfg_ch>=NUM_CH: write ignored, no state change.
- cfg write and count terminal on the same edge for the same channel: the write wins and no tick is produced.
- Other channels are unaffected by the write.
- busy_o[c] = armed[c] && ch_en[c], registered.

Test Plan:
- Reset values: DIV_INIT default, assert rst 2 cycles then ch_en=2'b11 -> tick_o[0] first high at edge 50000 after release, then every 50000 cycles; tick_o[1] every 6250; sq_o[0] period 100000; all outputs 0 during rst.
- Runtime divisor and boundaries: cfg write ch0 div=3 mid-count -> ticks 4 cycles after the write edge, then every 4 cycles. div=0 -> tick_o high continuously, sq_o toggles every cycle. div=16'hFFFF -> period 65536, no wrap glitch.
- One-shot: cfg ch1 div=5 mode=1 -> exactly one tick 6 cycles later, busy_o[1] falls on the same edge, no further ticks for 100 cycles. Second cfg write -> one more tick.
- Gating and alignment: drop ch_en[0] at cnt=2 for 10 cycles -> no ticks, count resumes at 3. Pulse sync_clr -> both channels restart; with equal div=7 both tick on the same edge thereafter.
- Collisions: cfg_we on the exact edge ch0 reaches div -> no tick that edge, new period starts. cfg_ch=5 with NUM_CH=2 -> no change. rst asserted mid-count -> next edge all state at reset values.
